// File: rtl/traffic_light_scheduler.sv
// Timed two-street intersection scheduler with a latched pedestrian request.
// Outputs are registered and decoded from the next state.
module traffic_light_scheduler #(
    parameter int MIN_GREEN     = 8,
    parameter int MAX_GREEN     = 32,
    parameter int YELLOW_CYCLES = 4,
    parameter int ALLRED_CYCLES = 2,
    parameter int WALK_CYCLES   = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       TA,
    input  logic       TB,
    input  logic       ped_req,
    output logic       ped_ack,
    output logic       walk,
    output logic [1:0] LA,
    output logic [1:0] LB
);

    localparam int M0 = (MAX_GREEN > YELLOW_CYCLES) ? MAX_GREEN : YELLOW_CYCLES;
    localparam int M1 = (M0 > ALLRED_CYCLES) ? M0 : ALLRED_CYCLES;
    localparam int TMAX = (M1 > WALK_CYCLES) ? M1 : WALK_CYCLES;
    localparam int TW = $clog2(TMAX) + 1;

    // Saturating at the longest duration keeps every phase exit reachable.
    localparam logic [TW-1:0] T_SAT = TW'(TMAX - 1);
    localparam logic [TW-1:0] T_MIN = TW'(MIN_GREEN - 1);
    localparam logic [TW-1:0] T_MAX = TW'(MAX_GREEN - 1);
    localparam logic [TW-1:0] T_YEL = TW'(YELLOW_CYCLES - 1);
    localparam logic [TW-1:0] T_CLR = TW'(ALLRED_CYCLES - 1);
    localparam logic [TW-1:0] T_WLK = TW'(WALK_CYCLES - 1);

    localparam logic [1:0] GREEN  = 2'b00;
    localparam logic [1:0] YELLOW = 2'b01;
    localparam logic [1:0] RED    = 2'b10;

    typedef enum logic [2:0] {
        A_GRN, A_YEL, A_CLR,
        B_GRN, B_YEL, B_CLR,
        WALK,  W_CLR
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic            pend_q, pend_d;
    logic            dir_b_q, dir_b_d;
    logic [1:0]      la_q, la_d;
    logic [1:0]      lb_q, lb_d;
    logic            walk_q, walk_d;
    logic            ack_q, ack_d;
    logic            demand_a, demand_b;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= A_GRN;
            timer_q <= '0;
            pend_q  <= 1'b0;
            dir_b_q <= 1'b1;
            la_q    <= GREEN;
            lb_q    <= RED;
            walk_q  <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            pend_q  <= pend_d;
            dir_b_q <= dir_b_d;
            la_q    <= la_d;
            lb_q    <= lb_d;
            walk_q  <= walk_d;
            ack_q   <= ack_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        dir_b_d  = dir_b_q;
        demand_a = TB | pend_q;
        demand_b = TA | pend_q;
        unique case (state_q)
            A_GRN: begin
                if (timer_q >= T_MIN && demand_a &&
                    (!TA || timer_q == T_MAX))
                    state_d = A_YEL;
            end
            A_YEL: if (timer_q == T_YEL) state_d = A_CLR;
            A_CLR: begin
                if (timer_q == T_CLR) begin
                    state_d = pend_q ? WALK : B_GRN;
                    dir_b_d = 1'b1;
                end
            end
            B_GRN: begin
                if (timer_q >= T_MIN && demand_b &&
                    (!TB || timer_q == T_MAX))
                    state_d = B_YEL;
            end
            B_YEL: if (timer_q == T_YEL) state_d = B_CLR;
            B_CLR: begin
                if (timer_q == T_CLR) begin
                    state_d = pend_q ? WALK : A_GRN;
                    dir_b_d = 1'b0;
                end
            end
            WALK:  if (timer_q == T_WLK) state_d = W_CLR;
            W_CLR: begin
                if (timer_q == T_CLR)
                    state_d = dir_b_q ? B_GRN : A_GRN;
            end
            default: state_d = A_GRN;
        endcase

        if (state_d != state_q)
            timer_d = '0;
        else if (timer_q == T_SAT)
            timer_d = timer_q;
        else
            timer_d = timer_q + TW'(1);

        // Entering WALK serves the request; requests seen during WALK are dropped.
        pend_d = pend_q;
        if (state_q != WALK) begin
            if (state_d == WALK)
                pend_d = 1'b0;
            else if (ped_req)
                pend_d = 1'b1;
        end
    end

    always_comb begin
        la_d   = RED;
        lb_d   = RED;
        walk_d = 1'b0;
        ack_d  = (state_d == WALK) && (state_q != WALK);
        unique case (state_d)
            A_GRN:   la_d = GREEN;
            A_YEL:   la_d = YELLOW;
            B_GRN:   lb_d = GREEN;
            B_YEL:   lb_d = YELLOW;
            WALK:    walk_d = 1'b1;
            default: ;
        endcase
    end

    assign LA      = la_q;
    assign LB      = lb_q;
    assign walk    = walk_q;
    assign ped_ack = ack_q;

endmodule

// File: tb/tb_traffic_light_scheduler.sv
// Bench for traffic_light_scheduler: directed scenarios plus random traffic,
// compared cycle by cycle with a phase/countdown reference model.
module tb_traffic_light_scheduler;

    localparam int MIN_G = 8;
    localparam int MAX_G = 32;
    localparam int YEL   = 4;
    localparam int CLR   = 2;
    localparam int WLK   = 6;
    localparam int HN    = 128;

    localparam logic [1:0] GREEN  = 2'b00;
    localparam logic [1:0] YELLOW = 2'b01;
    localparam logic [1:0] RED    = 2'b10;

    localparam int P_AG = 0, P_AY = 1, P_AC = 2, P_BG = 3;
    localparam int P_BY = 4, P_BC = 5, P_WK = 6, P_WC = 7;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       TA = 1'b0;
    logic       TB = 1'b0;
    logic       ped_req = 1'b0;
    logic       ped_ack;
    logic       walk;
    logic [1:0] LA;
    logic [1:0] LB;

    int checks = 0;
    int failures = 0;

    int ph, held, left;
    bit pend, go_b;

    logic [1:0] la_h [HN];
    logic [1:0] lb_h [HN];
    logic       wk_h [HN];
    logic       ak_h [HN];
    int         hk;

    traffic_light_scheduler #(
        .MIN_GREEN(MIN_G), .MAX_GREEN(MAX_G), .YELLOW_CYCLES(YEL),
        .ALLRED_CYCLES(CLR), .WALK_CYCLES(WLK)
    ) dut (
        .clk(clk), .reset(reset), .TA(TA), .TB(TB),
        .ped_req(ped_req), .ped_ack(ped_ack), .walk(walk),
        .LA(LA), .LB(LB)
    );

    always #5 clk = ~clk;

    function automatic int dur(input int p);
        case (p)
            P_AY, P_BY: return YEL;
            P_AC, P_BC, P_WC: return CLR;
            P_WK: return WLK;
            default: return 0;
        endcase
    endfunction

    function automatic logic [1:0] exp_la(input int p);
        if (p == P_AG) return GREEN;
        if (p == P_AY) return YELLOW;
        return RED;
    endfunction

    function automatic logic [1:0] exp_lb(input int p);
        if (p == P_BG) return GREEN;
        if (p == P_BY) return YELLOW;
        return RED;
    endfunction

    task automatic model_reset();
        ph = P_AG; held = 0; left = 0; pend = 0; go_b = 1;
    endtask

    task automatic model_step(input bit ta, input bit tb, input bit pr);
        int np;
        np = -1;
        case (ph)
            P_AG: if (held + 1 >= MIN_G && (tb || pend) &&
                      (!ta || held + 1 >= MAX_G)) np = P_AY;
            P_BG: if (held + 1 >= MIN_G && (ta || pend) &&
                      (!tb || held + 1 >= MAX_G)) np = P_BY;
            P_AY: if (left == 1) np = P_AC;
            P_BY: if (left == 1) np = P_BC;
            P_AC: if (left == 1) begin np = pend ? P_WK : P_BG; go_b = 1; end
            P_BC: if (left == 1) begin np = pend ? P_WK : P_AG; go_b = 0; end
            P_WK: if (left == 1) np = P_WC;
            P_WC: if (left == 1) np = go_b ? P_BG : P_AG;
            default: np = P_AG;
        endcase
        if (ph != P_WK) begin
            if (np == P_WK) pend = 0;
            else if (pr) pend = 1;
        end
        if (np >= 0) begin
            ph = np; held = 0; left = dur(np);
        end else begin
            held++; left--;
        end
    endtask

    task automatic check_outputs();
        logic exp_ak;
        exp_ak = (ph == P_WK) && (left == WLK);
        checks++;
        assert (LA === exp_la(ph)) else begin
            failures++;
            $error("FAIL LA: observed %0d expected %0d", LA, exp_la(ph));
        end
        checks++;
        assert (LB === exp_lb(ph)) else begin
            failures++;
            $error("FAIL LB: observed %0d expected %0d", LB, exp_lb(ph));
        end
        checks++;
        assert (walk === (ph == P_WK)) else begin
            failures++;
            $error("FAIL walk: observed %0b expected %0b", walk, ph == P_WK);
        end
        checks++;
        assert (ped_ack === exp_ak) else begin
            failures++;
            $error("FAIL ped_ack: observed %0b expected %0b", ped_ack, exp_ak);
        end
        checks++;
        assert (LA !== 2'b11 && LB !== 2'b11 && (LA === RED || LB === RED)) else begin
            failures++;
            $error("FAIL safety: observed LA=%0d LB=%0d required one RED, no 3", LA, LB);
        end
    endtask

    task automatic record();
        if (hk < HN) begin
            la_h[hk] = LA; lb_h[hk] = LB; wk_h[hk] = walk; ak_h[hk] = ped_ack;
            hk++;
        end
    endtask

    task automatic cyc(input bit ta, input bit tb, input bit pr);
        TA = ta; TB = tb; ped_req = pr;
        @(posedge clk);
        model_step(ta, tb, pr);
        #1;
        check_outputs();
        record();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        checks++;
        assert (LA === GREEN && LB === RED && walk === 1'b0 && ped_ack === 1'b0)
        else begin
            failures++;
            $error("FAIL reset_vals: observed LA=%0d LB=%0d walk=%0b ack=%0b expected 0 2 0 0",
                   LA, LB, walk, ped_ack);
        end
        @(posedge clk);
        #4;
        reset = 1'b0;
        model_reset();
        hk = 0;
        #1;
        check_outputs();
        record();
    endtask

    function automatic int cnt(input int sel, input logic [1:0] v,
                               input int lo, input int hi);
        int n;
        n = 0;
        for (int i = lo; i <= hi; i++) begin
            case (sel)
                0: if (la_h[i] === v) n++;
                1: if (lb_h[i] === v) n++;
                2: if (wk_h[i] === v[0]) n++;
                default: if (ak_h[i] === v[0]) n++;
            endcase
        end
        return n;
    endfunction

    task automatic expect_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        int ok;
        int n;
        bit ta, tb;
        #2;

        // Scenario 1: only B has traffic.
        do_reset();
        for (int i = 0; i < 20; i++) cyc(0, 1, 0);
        expect_int("t1_la_green", cnt(0, GREEN, 0, 19), 8);
        expect_int("t1_la_yellow", cnt(0, YELLOW, 0, 19), 4);
        expect_int("t1_lb_green", cnt(1, GREEN, 0, 19), 6);
        for (int i = 0; i < 50; i++) cyc(0, 1, 0);
        expect_int("t1_lb_holds", int'(lb_h[70]), int'(GREEN));

        // Scenario 2: both streets busy, max green enforced.
        do_reset();
        for (int i = 0; i < 80; i++) cyc(1, 1, 0);
        expect_int("t2_la_green", cnt(0, GREEN, 0, 39), 32);
        expect_int("t2_la_yellow", cnt(0, YELLOW, 0, 79), 4);
        expect_int("t2_lb_green", cnt(1, GREEN, 0, 79), 32);
        expect_int("t2_lb_yellow", int'(lb_h[70]), int'(YELLOW));

        // Scenario 3: no demand at all.
        do_reset();
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            cyc(0, 0, 0);
            if (LA === GREEN && LB === RED && !walk && !ped_ack) ok++;
        end
        expect_int("t3_idle", ok, 200);

        // Scenario 4: single pedestrian pulse.
        do_reset();
        for (int i = 0; i < 30; i++) cyc(0, 0, i == 3);
        expect_int("t4_green_end", int'(la_h[7]), int'(GREEN));
        expect_int("t4_yellow", int'(la_h[8]), int'(YELLOW));
        expect_int("t4_ack_once", cnt(3, 2'b01, 0, 29), 1);
        expect_int("t4_ack_at", int'(ak_h[14]), 1);
        expect_int("t4_walk_len", cnt(2, 2'b01, 0, 29), 6);
        expect_int("t4_clr", int'(lb_h[21]), int'(RED));
        expect_int("t4_lb_green", int'(lb_h[22]), int'(GREEN));

        // Scenario 6: request held through WALK, then a fresh request.
        do_reset();
        for (int i = 0; i < 60; i++) cyc(0, 0, i < 20);
        expect_int("t6_walk_len", cnt(2, 2'b01, 0, 59), 6);
        expect_int("t6_lb_holds", int'(lb_h[59]), int'(GREEN));
        cyc(0, 0, 1);
        for (int i = 0; i < 40; i++) cyc(0, 0, 0);
        expect_int("t6_second_walk", cnt(2, 2'b01, 60, 100), 6);
        expect_int("t6_back_to_a", int'(la_h[100]), int'(GREEN));

        // Scenario 5: asynchronous reset while B is yellow.
        do_reset();
        n = 0;
        while (ph != P_BY && n < 200) begin
            cyc(1, 1, 0);
            n++;
        end
        expect_int("t5_reached_byel", ph, P_BY);
        expect_int("t5_lb_yellow", int'(LB), int'(YELLOW));
        #3;
        do_reset();
        for (int i = 0; i < 20; i++) cyc(0, 1, 0);
        expect_int("t5_fresh_yellow", int'(la_h[8]), int'(YELLOW));

        // Random traffic, pedestrians and occasional resets.
        do_reset();
        ta = 0; tb = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) ta = ~ta;
            if ($urandom_range(0, 19) == 0) tb = ~tb;
            cyc(ta, tb, $urandom_range(0, 29) == 0);
            if ($urandom_range(0, 399) == 0) begin
                #3;
                do_reset();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
